// File: rtl/oitConstant.sv
// Elaboration-time helpers shared across blocks for sizing counters and fields.
package oitConstant;

  // Bits needed to hold 'value' as an unsigned number; never less than 1.
  function automatic int oitBits(input int value);
    int bits;
    bits = 1;
    while ((value >> bits) != 0) bits++;
    return bits;
  endfunction

endpackage

// File: rtl/wb_cmd_pkg.sv
// Shared types for the Wishbone B3 command master: completion codes, FSM states, fixed bus codes.
package wb_cmd_pkg;

  typedef enum logic [1:0] {
    OK         = 2'd0,
    ERR        = 2'd1,
    RETRY_FAIL = 2'd2,
    TIMEOUT    = 2'd3
  } wb_status_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUS     = 2'd1,
    ST_BACKOFF = 2'd2,
    ST_RESP    = 2'd3
  } wb_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wb_cmd_master_b3_if.sv
// Classic Wishbone B3 bus between one command master and one traffic-cop master slot.
interface wishbone_b3 #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_m2s;
  logic [DW-1:0] dat_s2m;
  logic [3:0]    sel;
  logic [2:0]    cti;
  logic [1:0]    bte;
  logic          ack;
  logic          err;
  logic          rty;

  modport master (
    output cyc, stb, we, adr, dat_m2s, sel, cti, bte,
    input  dat_s2m, ack, err, rty
  );

  modport slave (
    input  cyc, stb, we, adr, dat_m2s, sel, cti, bte,
    output dat_s2m, ack, err, rty
  );
endinterface

// File: rtl/wb_cmd_timer.sv
// Loadable saturating down-counter; expired_o is high while the count sits at zero.
// Clear has priority over load, load over decrement; no wrap below zero.
module wb_cmd_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                      cnt_d = '0;
    else if (load_i)                cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0)  cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/wb_cmd_master_b3.sv
// Valid/ready register command -> single classic Wishbone B3 cycle, with timeout and bounded retry.
// Command to cyc: 1 clk; response held until rsp_ready; one access per 3 clks at best.
module wb_cmd_master_b3
  import wb_cmd_pkg::*;
  import oitConstant::*;
#(
  parameter int addr_width     = 32,
  parameter int data_width     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [addr_width-1:0] req_adr,
  input  logic [data_width-1:0] req_dat,
  input  logic [3:0]            req_sel,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [data_width-1:0] rsp_dat,
  output logic [1:0]            rsp_status,
  wishbone_b3.master            wb
);

  localparam int            TW      = oitBits(TIMEOUT_CYCLES);
  localparam int            RW      = oitBits(MAX_RETRIES);
  localparam bit            TMO_EN  = (TIMEOUT_CYCLES != 0);
  localparam int            TLOAD   = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [TW-1:0] TLOAD_V = TW'(TLOAD);
  localparam logic [RW-1:0] MAXR_V  = RW'(MAX_RETRIES);

  wb_state_t             state_q, state_d;
  logic                  cyc_q, cyc_d;
  logic                  we_q, we_d;
  logic [addr_width-1:0] adr_q, adr_d;
  logic [data_width-1:0] dat_q, dat_d;
  logic [3:0]            sel_q, sel_d;
  logic [RW-1:0]         retry_q, retry_d;
  logic [data_width-1:0] rsp_dat_q, rsp_dat_d;
  wb_status_t            status_q, status_d;

  logic tmr_clr, tmr_load, tmr_dec, tmr_expired;

  // Loaded with TIMEOUT_CYCLES-1 on every BUS entry; expiry in a silent cycle aborts.
  wb_cmd_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (tmr_clr),
    .load_i     (tmr_load),
    .dec_i      (tmr_dec),
    .load_val_i (TLOAD_V),
    .expired_o  (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    retry_d   = retry_q;
    rsp_dat_d = rsp_dat_q;
    status_d  = status_q;
    tmr_clr   = 1'b0;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          adr_d    = req_adr;
          dat_d    = req_dat;
          sel_d    = req_sel;
          retry_d  = '0;
          tmr_load = 1'b1;
          cyc_d    = 1'b1;
          state_d  = ST_BUS;
        end
      end
      ST_BUS: begin
        // ack beats err beats rty when a slave raises several together.
        if (wb.ack) begin
          rsp_dat_d = we_q ? '0 : wb.dat_s2m;
          status_d  = OK;
          cyc_d     = 1'b0;
          tmr_clr   = 1'b1;
          state_d   = ST_RESP;
        end else if (wb.err) begin
          rsp_dat_d = '0;
          status_d  = ERR;
          cyc_d     = 1'b0;
          tmr_clr   = 1'b1;
          state_d   = ST_RESP;
        end else if (wb.rty) begin
          cyc_d = 1'b0;
          if (retry_q < MAXR_V) begin
            retry_d = retry_q + RW'(1);
            state_d = ST_BACKOFF;
          end else begin
            rsp_dat_d = '0;
            status_d  = RETRY_FAIL;
            tmr_clr   = 1'b1;
            state_d   = ST_RESP;
          end
        end else if (TMO_EN && tmr_expired) begin
          rsp_dat_d = '0;
          status_d  = TIMEOUT;
          cyc_d     = 1'b0;
          state_d   = ST_RESP;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_BACKOFF: begin
        tmr_load = 1'b1;
        cyc_d    = 1'b1;
        state_d  = ST_BUS;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      retry_q   <= '0;
      rsp_dat_q <= '0;
      status_q  <= OK;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      retry_q   <= retry_d;
      rsp_dat_q <= rsp_dat_d;
      status_q  <= status_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_dat    = rsp_dat_q;
  assign rsp_status = status_q;

  assign wb.cyc     = cyc_q;
  assign wb.stb     = cyc_q;
  assign wb.we      = we_q;
  assign wb.adr     = adr_q;
  assign wb.dat_m2s = dat_q;
  assign wb.sel     = sel_q;
  assign wb.cti     = CTI_CLASSIC;
  assign wb.bte     = BTE_LINEAR;

endmodule

// File: tb/tb_wb_cmd_master_b3.sv
// Scoreboarded bench for wb_cmd_master_b3: programmable slave, cycle-shape monitor, response checks.
module tb_wb_cmd_master_b3;
  import wb_cmd_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_adr, req_dat;
  logic [3:0]  req_sel;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;

  logic        r0_valid, r0_ready, r0_rsp_valid;
  logic [31:0] r0_rsp_dat;
  logic [1:0]  r0_rsp_status;

  wishbone_b3 #(.AW(32), .DW(32)) wb ();
  wishbone_b3 #(.AW(32), .DW(32)) wb0 ();

  wb_cmd_master_b3 #(.addr_width(32), .data_width(32), .TIMEOUT_CYCLES(8), .MAX_RETRIES(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_adr(req_adr), .req_dat(req_dat), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_status(rsp_status),
    .wb(wb)
  );

  // Second instance with the timeout disabled, facing a silent slave.
  wb_cmd_master_b3 #(.addr_width(32), .data_width(32), .TIMEOUT_CYCLES(0), .MAX_RETRIES(3)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(r0_valid), .req_ready(r0_ready), .req_we(1'b0),
    .req_adr(32'h0000_0100), .req_dat(32'h0), .req_sel(4'hF),
    .rsp_valid(r0_rsp_valid), .rsp_ready(1'b0), .rsp_dat(r0_rsp_dat), .rsp_status(r0_rsp_status),
    .wb(wb0)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0]  st;
    logic [31:0] dat;
  } exp_t;
  exp_t sb_q[$];

  // Slave behaviour: 0 silent, 1 ack at cycle sdly, 2 err at sdly, 3 ack+err, 4 rty for srty phases then ack
  int          smode = 0, sdly = 1, srty = 0;
  logic [31:0] sdat = '0;

  int          run_len = 0, gap_len = 0, phases = 0, total = 0, adr_chg = 0;
  bit          txn_done = 1'b1;
  logic        cap_we;
  logic [3:0]  cap_sel;
  logic [4:0]  cap_cti_bte;
  logic [31:0] cap_adr, cap_dat;

  initial begin
    wb.ack = 1'b0; wb.err = 1'b0; wb.rty = 1'b0; wb.dat_s2m = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n || rsp_valid) txn_done = 1'b1;
      if (wb.cyc) begin
        if (run_len == 0) begin
          if (txn_done) begin
            txn_done = 1'b0; phases = 0; total = 0; adr_chg = 0;
            cap_we = wb.we; cap_sel = wb.sel; cap_adr = wb.adr; cap_dat = wb.dat_m2s;
            cap_cti_bte = {wb.cti, wb.bte};
          end else begin
            check_eq("backoff_gap", gap_len, 1);
          end
          phases++;
        end
        run_len++; total++; gap_len = 0;
        if (wb.adr !== cap_adr) adr_chg++;
      end else begin
        run_len = 0; gap_len++;
      end
      wb.ack = 1'b0; wb.err = 1'b0; wb.rty = 1'b0; wb.dat_s2m = '0;
      if (wb.cyc && wb.stb) begin
        case (smode)
          1: if (run_len == sdly) begin wb.ack = 1'b1; wb.dat_s2m = sdat; end
          2: if (run_len == sdly) begin wb.err = 1'b1; wb.dat_s2m = sdat; end
          3: if (run_len == 1) begin wb.ack = 1'b1; wb.err = 1'b1; wb.dat_s2m = sdat; end
          4: if (run_len == 1) begin
               if (phases <= srty) wb.rty = 1'b1;
               else begin wb.ack = 1'b1; wb.dat_s2m = sdat; end
             end
          default: ;
        endcase
      end
    end
  end

  task automatic send(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input bit push, input logic [1:0] est,
                      input logic [31:0] edat);
    int   n;
    exp_t e;
    n = 0;
    if (push) begin
      e.st = est; e.dat = edat;
      sb_q.push_back(e);
    end
    @(negedge clk);
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    if (!req_ready) check_eq("req_ready_wait", 0, 1);
    req_we = we; req_adr = adr; req_dat = dat; req_sel = sel; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
  endtask

  task automatic get_rsp(input int hold);
    int          n, unstable;
    exp_t        e;
    logic [31:0] d0;
    logic [1:0]  s0;
    n = 0; unstable = 0;
    @(negedge clk);
    while (!rsp_valid && n < 2000) begin @(negedge clk); n++; end
    if (!rsp_valid) begin
      check_eq("rsp_wait", 0, 1);
      return;
    end
    d0 = rsp_dat; s0 = rsp_status;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_dat !== d0 || rsp_status !== s0 || req_ready) unstable++;
    end
    if (hold > 0) check_eq("rsp_hold_stable", unstable, 0);
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    check_eq("post_hs_valid_ready", {rsp_valid, req_ready}, 2'b01);
    if (sb_q.size() == 0) check_eq("sb_underflow", 0, 1);
    else begin
      e = sb_q.pop_front();
      check_eq("rsp_status", s0, e.st);
      check_eq("rsp_dat", d0, e.dat);
    end
  endtask

  initial begin
    int bad;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_dat = '0; req_sel = '0;
    rsp_ready = 1'b0; r0_valid = 1'b0;
    wb0.ack = 1'b0; wb0.err = 1'b0; wb0.rty = 1'b0; wb0.dat_s2m = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cyc_stb_we", {wb.cyc, wb.stb, wb.we}, 3'b000);
    check_eq("rst_adr_dat", {wb.adr, wb.dat_m2s}, 64'h0);
    check_eq("rst_sel_cti_bte", {wb.sel, wb.cti, wb.bte}, 9'h0);
    check_eq("rst_req_rsp", {req_ready, rsp_valid}, 2'b10);
    check_eq("rst_rsp_fields", {rsp_dat, rsp_status}, 34'h0);
    @(negedge clk) rst_n = 1'b1;

    // Read, ack in second BUS cycle
    smode = 1; sdly = 2; sdat = 32'hDEAD_BEEF;
    send(1'b0, 32'h0000_0010, 32'h0, 4'hF, 1'b1, OK, 32'hDEAD_BEEF);
    get_rsp(0);
    check_eq("read_cyc_len", total, 2);
    check_eq("read_adr", cap_adr, 32'h0000_0010);

    // Write, immediate ack
    smode = 1; sdly = 1; sdat = 32'h5555_AAAA;
    send(1'b1, 32'h0000_0020, 32'h1234_5678, 4'b0011, 1'b1, OK, 32'h0);
    get_rsp(0);
    check_eq("write_we_sel", {cap_we, cap_sel}, 5'b1_0011);
    check_eq("write_dat", cap_dat, 32'h1234_5678);
    check_eq("write_cti_bte", cap_cti_bte, 5'b0);
    check_eq("write_cyc_len", total, 1);

    // Two retries then ack
    smode = 4; srty = 2; sdat = 32'hA5A5_0001;
    send(1'b0, 32'h0000_0040, 32'h0, 4'hF, 1'b1, OK, 32'hA5A5_0001);
    get_rsp(0);
    check_eq("retry_phases", phases, 3);
    check_eq("retry_adr_stable", adr_chg, 0);

    // Retry forever: MAX_RETRIES+1 bus phases then fail
    smode = 4; srty = 99;
    send(1'b0, 32'h0000_0044, 32'h0, 4'hF, 1'b1, RETRY_FAIL, 32'h0);
    get_rsp(0);
    check_eq("retryfail_phases", phases, 4);

    // Silent slave, 8-cycle timeout
    smode = 0;
    send(1'b0, 32'h0000_0048, 32'h0, 4'hF, 1'b1, TIMEOUT, 32'h0);
    get_rsp(0);
    check_eq("timeout_cyc_len", total, 8);
    check_eq("timeout_phases", phases, 1);

    // ack and err together: ack wins
    smode = 3; sdat = 32'hCAFE_0000;
    send(1'b0, 32'h0000_004C, 32'h0, 4'hF, 1'b1, OK, 32'hCAFE_0000);
    get_rsp(0);

    // err alone, consumer stalls 5 clks
    smode = 2; sdly = 3; sdat = 32'h0BAD_0BAD;
    send(1'b0, 32'h0000_0050, 32'h0, 4'hF, 1'b1, ERR, 32'h0);
    get_rsp(5);
    check_eq("err_cyc_len", total, 3);

    // Reset in the middle of a bus cycle
    smode = 0;
    send(1'b0, 32'h0000_0060, 32'h0, 4'hF, 1'b0, OK, 32'h0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_eq("async_rst_cyc_stb", {wb.cyc, wb.stb}, 2'b00);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 check_eq("post_rst_ready_valid", {req_ready, rsp_valid}, 2'b10);
    bad = 0;
    repeat (10) begin @(negedge clk); if (rsp_valid) bad++; end
    check_eq("post_rst_no_rsp", bad, 0);
    smode = 1; sdly = 1; sdat = 32'h7777_0001;
    send(1'b0, 32'h0000_0064, 32'h0, 4'hF, 1'b1, OK, 32'h7777_0001);
    get_rsp(0);

    // Timeout disabled: cyc stays up indefinitely
    @(negedge clk) r0_valid = 1'b1;
    @(posedge clk); #1 r0_valid = 1'b0;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (!wb0.cyc || !wb0.stb || r0_rsp_valid || r0_ready) bad++;
    end
    check_eq("no_timeout_hold", bad, 0);
    check_eq("no_timeout_rsp_fields", {r0_rsp_dat, r0_rsp_status}, 34'h0);

    check_eq("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_cmd_master_b3.md
Name: wb_cmd_master_b3

Overview:
Converts a simple valid/ready register-access command port into single classic Wishbone B3 master cycles. One instance per command source: debug/JTAG, UART monitor, or boot loader. Each instance drives one master slot of the bus traffic cop upstream of the address expander. It adds per-access timeout and bounded retry handling, so a dead or busy slave never hangs the command source.

Parameters:
addr_width, 32, width of req_adr and wb.adr
data_width, 32, width of req_dat, rsp_dat and the wb data buses
TIMEOUT_CYCLES, 255, bus cycles to wait for ack/err/rty before abort; 0 disables the timeout
MAX_RETRIES, 3, number of rty responses tolerated before the access fails; 0 means the first rty fails

Ports:
clk  input  1  system clock; all logic on posedge
rst_n  input  1  asynchronous, active-low reset
req_valid  input  1  command present
req_ready  output  1  block can accept a command
req_we  input  1  1 = write, 0 = read
req_adr  input  addr_width  byte address
req_dat  input  data_width  write data
req_sel  input  4  byte lane select
rsp_valid  output  1  response present
rsp_ready  input  1  consumer takes response
rsp_dat  output  data_width  read data; 0 for writes and for failed accesses
rsp_status  output  2  completion code, see package
wb  interface  wishbone_b3.master  bus toward one traffic-cop master slot

Behaviour:
- Reset (async, immediate):
  - wb.cyc, wb.stb, wb.we = 0; wb.adr, wb.dat_m2s, wb.sel, wb.cti = 0; wb.bte = 0.
  - req_ready = 1; rsp_valid = 0; rsp_dat = 0; rsp_status = OK.
  - Timeout counter and retry counter = 0. FSM = IDLE.
  - Reset during an access drops cyc/stb asynchronously. No response is produced.
- FSM states: IDLE, BUS, BACKOFF, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready at edge N: latch we/adr/dat/sel and clear both counters.
  - wb.cyc = wb.stb = 1 from cycle N+1 (state BUS).
- BUS:
  - req_ready = 0. All wb outputs are registered and held stable.
  - wb.cti = 3'b000 (classic). wb.bte = 0.
  - Sampled response priority when several are asserted together: ack > err > rty.
  - ack: rsp_dat = wb.dat_s2m for reads, 0 for writes. Status OK. Go to RESP.
  - err: rsp_dat = 0. Status ERR. Go to RESP.
  - rty with retry count < MAX_RETRIES: increment retry count, go to BACKOFF.
  - rty with retry count == MAX_RETRIES: status RETRY_FAIL. Go to RESP.
  - No response: increment the timeout counter. When it reaches TIMEOUT_CYCLES-1 with no response that cycle: status TIMEOUT, rsp_dat = 0, go to RESP.
  - cyc/stb deassert on the same edge that leaves BUS.
  - Minimum cycle: ack in the first BUS cycle gives cyc high for exactly 1 clk.
- BACKOFF:
  - Exactly 1 cycle with cyc = stb = 0. This lets the traffic cop re-arbitrate.
  - Clear the timeout counter, then return to BUS with the same latched fields.
- RESP:
  - rsp_valid = 1; rsp_dat and rsp_status are held stable.
  - On rsp_valid & rsp_ready: rsp_valid = 0 next cycle and go to IDLE. req_ready returns to 1 on that same next cycle.
  - No command is accepted in the RESP cycle itself (no bypass).
  - Maximum throughput is one access per 3 clks.
- Counter widths are sized by oitBits for TIMEOUT_CYCLES and MAX_RETRIES. Counters saturate and never wrap.
- Slave responses that arrive outside BUS are ignored.

Decomposition:
- Package wb_cmd_pkg holds:
  - typedef enum logic [1:0] wb_status_t: OK = 0, ERR = 1, RETRY_FAIL = 2, TIMEOUT = 3.
  - The FSM state enum.
- oitBits is reused from oitConstant.sv.
- One sub-module: wb_cmd_timer. It is a loadable saturating down-counter with clear, load and expire outputs, and is shared by the timeout logic. The retry counter stays inline.

Test Plan:
- Read at adr 0x0000_0010; slave acks with data 0xDEADBEEF on the 2nd BUS cycle -> cyc high exactly 2 clks; rsp_dat = 0xDEADBEEF, status OK; req_ready back 1 clk after the rsp handshake.
- Write 0x1234_5678, sel 4'b0011; slave acks immediately -> wb.we = 1, wb.sel = 0011, wb.dat_m2s = 0x12345678 held for 1 clk; rsp_dat = 0, status OK.
- Slave asserts rty twice then ack (MAX_RETRIES = 3) -> two 1-clk cyc-low gaps, address unchanged; final status OK. Same test with rty forever -> exactly 4 BUS phases, then status RETRY_FAIL.
- No slave response (null slave with err tied 0), TIMEOUT_CYCLES = 8 -> cyc high exactly 8 clks, status TIMEOUT, rsp_dat = 0. Repeat with TIMEOUT_CYCLES = 0 -> cyc stays high for 1000 clks with no response.
- ack and err asserted in the same cycle -> status OK. err alone -> status ERR. rsp_ready held low for 5 clks -> rsp_valid and rsp fields stable, req_ready = 0 throughout.
- rst_n pulsed low mid-BUS -> cyc/stb = 0 asynchronously before the next clk edge; no rsp_valid; req_ready = 1 after release; the next access completes normally.
